// File: rtl/rob_commit_pkg.sv
// Shared widths and the reorder-buffer entry record used by rob_commit.
package rob_commit_pkg;

    localparam int ROB_DEPTH = 16;  // ROB_SIZE
    localparam int ROB_LEN   = 4;   // tag width, log2(ROB_DEPTH)
    localparam int REG_LEN   = 5;
    localparam int DATA_LEN  = 32;

    typedef struct packed {
        logic                busy;
        logic                rdy;
        logic [REG_LEN-1:0]  rd;
        logic                is_store;
        logic                is_branch;
        logic                mispredict;
        logic [DATA_LEN-1:0] val;
        logic [DATA_LEN-1:0] target;
    } rob_entry_t;

    // ROB_ARR: the full entry array
    typedef rob_entry_t [ROB_DEPTH-1:0] rob_arr_t;

endpackage

// File: rtl/rob_commit.sv
// 16-entry reorder buffer: in-order allocate, out-of-order writeback on two ports,
// in-order retirement with register unlock, store release and mispredict flush.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int ROB_SIZE = ROB_DEPTH,
    parameter int ROB_W    = ROB_LEN
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ready,
    input  logic                issue_valid,
    input  logic [REG_LEN-1:0]  issue_rd,
    input  logic                issue_is_store,
    input  logic                issue_is_branch,
    output logic [ROB_W-1:0]    issue_robpos,
    output logic                full,
    input  logic                alu_wb_valid,
    input  logic [ROB_W-1:0]    alu_wb_robpos,
    input  logic [DATA_LEN-1:0] alu_wb_val,
    input  logic                alu_wb_mispredict,
    input  logic [DATA_LEN-1:0] alu_wb_target,
    input  logic                lsb_wb_valid,
    input  logic [ROB_W-1:0]    lsb_wb_robpos,
    input  logic [DATA_LEN-1:0] lsb_wb_val,
    input  logic [ROB_W-1:0]    q1_robpos,
    input  logic [ROB_W-1:0]    q2_robpos,
    output logic                q1_ready,
    output logic                q2_ready,
    output logic [DATA_LEN-1:0] q1_val,
    output logic [DATA_LEN-1:0] q2_val,
    output logic                commit_valid,
    output logic [REG_LEN-1:0]  commit_rd,
    output logic [ROB_W-1:0]    commit_robpos,
    output logic [DATA_LEN-1:0] commit_val,
    output logic                store_commit,
    output logic                clear,
    output logic [DATA_LEN-1:0] clear_pc
);

    localparam logic [ROB_W-1:0] PTR_ONE = 1;
    localparam logic [ROB_W:0]   CNT_MAX = (ROB_W+1)'(ROB_SIZE);

    rob_entry_t [ROB_SIZE-1:0] ent_q, ent_d;
    logic [ROB_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [ROB_W:0]      count_q, count_d;
    logic                cv_q, cv_d, sc_q, sc_d, clr_q, clr_d;
    logic [REG_LEN-1:0]  crd_q, crd_d;
    logic [ROB_W-1:0]    crob_q, crob_d;
    logic [DATA_LEN-1:0] cval_q, cval_d, cpc_q, cpc_d;
    logic                do_issue, do_commit;

    assign full         = (count_q == CNT_MAX);
    assign issue_robpos = tail_q;

    // Queries see registered state only; a same-cycle writeback is not bypassed.
    assign q1_ready = ent_q[q1_robpos].busy && ent_q[q1_robpos].rdy;
    assign q2_ready = ent_q[q2_robpos].busy && ent_q[q2_robpos].rdy;
    assign q1_val   = q1_ready ? ent_q[q1_robpos].val : '0;
    assign q2_val   = q2_ready ? ent_q[q2_robpos].val : '0;

    assign do_issue  = ready && !clr_q && issue_valid && !full;
    assign do_commit = ready && !clr_q && ent_q[head_q].busy && ent_q[head_q].rdy;

    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        cv_d    = cv_q;
        sc_d    = sc_q;
        clr_d   = clr_q;
        crd_d   = crd_q;
        crob_d  = crob_q;
        cval_d  = cval_q;
        cpc_d   = cpc_q;
        if (ready) begin
            cv_d  = 1'b0;
            sc_d  = 1'b0;
            clr_d = 1'b0;
            if (!clr_q) begin
                if (alu_wb_valid && ent_q[alu_wb_robpos].busy) begin
                    ent_d[alu_wb_robpos].rdy        = 1'b1;
                    ent_d[alu_wb_robpos].val        = alu_wb_val;
                    ent_d[alu_wb_robpos].mispredict = alu_wb_mispredict;
                    ent_d[alu_wb_robpos].target     = alu_wb_target;
                end
                if (lsb_wb_valid && ent_q[lsb_wb_robpos].busy) begin
                    ent_d[lsb_wb_robpos].rdy = 1'b1;
                    ent_d[lsb_wb_robpos].val = lsb_wb_val;
                end
                if (do_issue) begin
                    ent_d[tail_q] = '{busy: 1'b1, rdy: 1'b0, rd: issue_rd,
                                      is_store: issue_is_store, is_branch: issue_is_branch,
                                      mispredict: 1'b0, val: '0, target: '0};
                    tail_d = tail_q + PTR_ONE;
                end
                count_d = count_q + (ROB_W+1)'(do_issue) - (ROB_W+1)'(do_commit);
                if (do_commit) begin
                    cv_d   = 1'b1;
                    crd_d  = ent_q[head_q].rd;
                    crob_d = head_q;
                    cval_d = ent_q[head_q].val;
                    sc_d   = ent_q[head_q].is_store;
                    ent_d[head_q].busy = 1'b0;
                    ent_d[head_q].rdy  = 1'b0;
                    head_d = head_q + PTR_ONE;
                    // Mispredicted branch retires, then everything younger is squashed.
                    if (ent_q[head_q].is_branch && ent_q[head_q].mispredict) begin
                        clr_d   = 1'b1;
                        cpc_d   = ent_q[head_q].target;
                        head_d  = '0;
                        tail_d  = '0;
                        count_d = '0;
                        for (int i = 0; i < ROB_SIZE; i++) begin
                            ent_d[i].busy = 1'b0;
                            ent_d[i].rdy  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cv_q    <= 1'b0;
            sc_q    <= 1'b0;
            clr_q   <= 1'b0;
            crd_q   <= '0;
            crob_q  <= '0;
            cval_q  <= '0;
            cpc_q   <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cv_q    <= cv_d;
            sc_q    <= sc_d;
            clr_q   <= clr_d;
            crd_q   <= crd_d;
            crob_q  <= crob_d;
            cval_q  <= cval_d;
            cpc_q   <= cpc_d;
        end
    end

    assign commit_valid  = cv_q;
    assign commit_rd     = crd_q;
    assign commit_robpos = crob_q;
    assign commit_val    = cval_q;
    assign store_commit  = sc_q;
    assign clear         = clr_q;
    assign clear_pc      = cpc_q;

endmodule
